// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle instruction sequencer for the 8-bit CPU datapath.
// Fetches instructions from program ROM (req/ack), decodes them and drives
// the A-input mux select, register load enables and ALU opcode.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | stopped at an instruction boundary, waiting for run
// FETCH  | rom_req held until rom_ack; latch ir, advance pc
// DECODE | one quiet cycle; JMP updates pc here
// EXEC   | ALU instruction: alu_op presented for one cycle
// WB     | one cycle of register write strobes
// HALT   | halted; only reset leaves this state
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   run                1 = execute, 0 = stop at next instruction boundary
//   rom_req/rom_addr   fetch request (held until ack) and address (= pc)
//   rom_ack/rom_data   single-cycle data-valid pulse and instruction byte
//   reg_sel4           A-input mux select (0=alu_out, 1=B, 2=C, 3=D)
//   ld_a..ld_d         register load enables
//   alu_op             ALU operation select
//   busy, halted       status
module cpu_seq #(
  parameter int PC_W = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [7:0]      rom_data,
  output logic [1:0]      reg_sel4,
  output logic            ld_a,
  output logic            ld_b,
  output logic            ld_c,
  output logic            ld_d,
  output logic [1:0]      alu_op,
  output logic            busy,
  output logic            halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_CTL = 2'b11;

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic [PC_W-1:0] jmp_target;

  // JMP target is a 4-bit field, zero-extended to the pc width.
  assign jmp_target = PC_W'(ir[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (rom_ack) begin
            ir    <= rom_data;
            pc    <= pc + 1'b1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (ir[7:6])
            OP_ALU: state <= S_EXEC;
            OP_CTL: begin
              if (ir[5]) begin
                state <= S_HALT;
              end else begin
                pc    <= jmp_target;
                state <= run ? S_FETCH : S_IDLE;
              end
            end
            default: state <= S_WB;
          endcase
        end
        S_EXEC:  state <= S_WB;
        S_WB:    state <= run ? S_FETCH : S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr = pc;

  always_comb begin
    rom_req  = 1'b0;
    reg_sel4 = 2'd0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_c     = 1'b0;
    ld_d     = 1'b0;
    alu_op   = 2'd0;
    busy     = 1'b1;
    halted   = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_FETCH: rom_req = 1'b1;
      S_EXEC: begin
        if (ir[7:6] == OP_ALU) alu_op = ir[1:0];
      end
      S_WB: begin
        case (ir[7:6])
          OP_MOV: begin
            reg_sel4 = ir[1:0];
            ld_a     = 1'b1;
          end
          OP_ALU: begin
            alu_op = ir[1:0];
            ld_a   = 1'b1;
          end
          OP_ST: begin
            // dst 0 is a NOP store: no enable asserted.
            ld_b = (ir[1:0] == 2'd1);
            ld_c = (ir[1:0] == 2'd2);
            ld_d = (ir[1:0] == 2'd3);
          end
          default: ;
        endcase
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_seq.sv
// Scoreboard bench for cpu_seq: stimulus pushes expected output events,
// a monitor recognises events on the DUT outputs and compares them in order.
module tb_cpu_seq;

  localparam logic [2:0] EV_FSTART = 3'd0; // rom_req rises, data = rom_addr
  localparam logic [2:0] EV_FEND   = 3'd1; // rom_req falls, data = cycles held
  localparam logic [2:0] EV_EXEC   = 3'd2; // alu_op without load, data = alu_op
  localparam logic [2:0] EV_WB     = 3'd3; // any load, data = {sel,a,b,c,d,op}
  localparam logic [2:0] EV_HALT   = 3'd4; // halted rises, data = {busy,rom_req}

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       rom_req;
  logic [3:0] rom_addr;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic [1:0] reg_sel4;
  logic       ld_a, ld_b, ld_c, ld_d;
  logic [1:0] alu_op;
  logic       busy;
  logic       halted;

  int compared = 0;
  int mismatched = 0;
  ev_t exp_q[$];
  logic mon_en = 1'b0;

  logic [7:0] rom [16];
  int         dly [16];

  cpu_seq #(.PC_W(4), .RESET_PC(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .reg_sel4(reg_sel4), .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_d(ld_d),
    .alu_op(alu_op), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] wbv(input logic [1:0] sel, input logic a, input logic b,
                                     input logic c, input logic d, input logic [1:0] op);
    return {sel, a, b, c, d, op};
  endfunction

  task automatic push(input logic [2:0] kind, input logic [7:0] data);
    exp_q.push_back('{kind: kind, data: data});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting, got nothing expected event", name);
  endtask

  // ROM responder: ack after dly[addr] wait cycles, single-cycle pulse.
  initial begin
    int  wait_cnt;
    bit  given;
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    wait_cnt = 0;
    given    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rom_ack = 1'b0;
      if (rom_req === 1'b1 && !given) begin
        if (wait_cnt >= dly[rom_addr]) begin
          rom_ack  = 1'b1;
          rom_data = rom[rom_addr];
          given    = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (rom_req !== 1'b1) given = 1'b0;
    end
  end

  // Monitor: detect output events at the falling edge and score them.
  task automatic score(input ev_t got);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got kind=%0d data=%0h expected no event", got.kind, got.data);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        mismatched++;
        $display("FAIL event: got kind=%0d data=%0h expected kind=%0d data=%0h",
                 got.kind, got.data, e.kind, e.data);
      end
    end
  endtask

  initial begin
    logic prev_req;
    logic prev_halt;
    int   req_len;
    prev_req  = 1'b0;
    prev_halt = 1'b0;
    req_len   = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rom_req && !prev_req) score('{kind: EV_FSTART, data: {4'd0, rom_addr}});
        if (!rom_req && prev_req) score('{kind: EV_FEND, data: 8'(req_len)});
        if ((alu_op != 2'd0) && !(ld_a | ld_b | ld_c | ld_d))
          score('{kind: EV_EXEC, data: {6'd0, alu_op}});
        if (ld_a | ld_b | ld_c | ld_d)
          score('{kind: EV_WB, data: wbv(reg_sel4, ld_a, ld_b, ld_c, ld_d, alu_op)});
        if (halted && !prev_halt) score('{kind: EV_HALT, data: {6'd0, busy, rom_req}});
      end
      if (!rom_req) req_len = 0;
      else req_len++;
      prev_req  = rom_req;
      prev_halt = halted;
    end
  end

  initial begin
    bit seen;
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'h00;
      dly[i] = 0;
    end
    rst_n = 1'b0;
    run   = 1'b0;

    // Reset values are visible before any clock edge.
    #1;
    chk("rst_rom_req", rom_req, 0);
    chk("rst_outputs", {reg_sel4, ld_a, ld_b, ld_c, ld_d, alu_op, busy, halted}, 0);
    chk("rst_rom_addr", rom_addr, 0);

    // Asynchronous reset in the WB cycle of an ALU instruction.
    rom[0] = 8'h41;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (ld_a === 1'b1) seen = 1'b1;
    end
    if (!seen) timeout("wb_before_reset");
    chk("pre_rst_alu_op", alu_op, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ld_a", ld_a, 0);
    chk("async_rst_alu_op", alu_op, 0);
    chk("async_rst_rom_req", rom_req, 0);
    chk("async_rst_rom_addr", rom_addr, 0);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rom_req", rom_req, 0);
    chk("idle_rom_addr", rom_addr, 0);

    // Main program: MOV, ALU with delayed ack, ST b/d/nop, JMPs, wrap, HALT.
    rom[0]  = 8'h02;
    rom[1]  = 8'h43; dly[1] = 3;
    rom[2]  = 8'h81;
    rom[3]  = 8'h83;
    rom[4]  = 8'hC5;
    rom[5]  = 8'h80;
    rom[6]  = 8'hCF;
    rom[15] = 8'h01;
    push(EV_FSTART, 8'd0);  push(EV_FEND, 8'd1); push(EV_WB, wbv(2'd2, 1, 0, 0, 0, 2'd0));
    push(EV_FSTART, 8'd1);  push(EV_FEND, 8'd4); push(EV_EXEC, 8'd3);
    push(EV_WB, wbv(2'd0, 1, 0, 0, 0, 2'd3));
    push(EV_FSTART, 8'd2);  push(EV_FEND, 8'd1); push(EV_WB, wbv(2'd0, 0, 1, 0, 0, 2'd0));
    push(EV_FSTART, 8'd3);  push(EV_FEND, 8'd1); push(EV_WB, wbv(2'd0, 0, 0, 0, 1, 2'd0));
    push(EV_FSTART, 8'd4);  push(EV_FEND, 8'd1);
    push(EV_FSTART, 8'd5);  push(EV_FEND, 8'd1);
    push(EV_FSTART, 8'd6);  push(EV_FEND, 8'd1);
    push(EV_FSTART, 8'd15); push(EV_FEND, 8'd1); push(EV_WB, wbv(2'd1, 1, 0, 0, 0, 2'd0));
    push(EV_FSTART, 8'd0);  push(EV_FEND, 8'd1); push(EV_HALT, 8'd0);
    mon_en = 1'b1;
    run    = 1'b1;
    repeat (4) @(negedge clk);
    rom[0] = 8'hE0; // second visit to address 0 (after wrap) halts
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge clk);
      if (halted === 1'b1) seen = 1'b1;
    end
    if (!seen) timeout("halt");
    chk("halt_busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      run = i[0];
      @(negedge clk);
    end
    chk("halt_stays", {halted, rom_req, busy}, 3'b100);
    chk("prog_queue_drained", exp_q.size(), 0);

    // run dropped during EXEC: WB completes, then IDLE; resume at pc.
    run   = 1'b0;
    rst_n = 1'b0;
    rom[0] = 8'h42;
    rom[1] = 8'h02;
    dly[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push(EV_FSTART, 8'd0); push(EV_FEND, 8'd1); push(EV_EXEC, 8'd2);
    push(EV_WB, wbv(2'd0, 1, 0, 0, 0, 2'd2));
    run  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (alu_op != 2'd0 && ld_a === 1'b0) seen = 1'b1;
    end
    if (!seen) timeout("exec");
    run = 1'b0;
    repeat (5) @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_rom_req", rom_req, 0);
    chk("stop_rom_addr", rom_addr, 1);

    push(EV_FSTART, 8'd1); push(EV_FEND, 8'd1); push(EV_WB, wbv(2'd2, 1, 0, 0, 0, 2'd0));
    run  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (ld_a === 1'b1) seen = 1'b1;
    end
    if (!seen) timeout("resume_wb");
    run = 1'b0;
    repeat (4) @(negedge clk);
    chk("resume_stop_busy", busy, 0);
    chk("resume_rom_addr", rom_addr, 2);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
